// File: rtl/pipe_stage_latch_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_latch_if
//  Purpose  : Handshake bundle between two pipeline stages and the
//             inter-stage latch that sits between them.
//  Signals  : in_valid/in_ready/in_data  - upstream side (producer -> latch)
//             flush                      - synchronous squash request
//             out_valid/out_ready/out_data - downstream side (latch -> consumer)
//             occupancy                  - number of entries held (0..2)
//  Modports : slave  - the latch itself
//             master - the environment driving and consuming the latch
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_stage_latch_if #(
    parameter int DATA_W   = 32,
    parameter int N_FIELDS = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic [N_FIELDS*DATA_W-1:0]   in_data;
    logic                         flush;
    logic                         out_valid;
    logic                         out_ready;
    logic [N_FIELDS*DATA_W-1:0]   out_data;
    logic [1:0]                   occupancy;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  flush,
        output out_valid,
        input  out_ready,
        output out_data,
        output occupancy
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output flush,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  occupancy
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_latch.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_latch
//  Purpose  : Parametrised inter-stage pipeline register with a valid/ready
//             handshake, a 2-entry skid buffer (full throughput under
//             backpressure), synchronous flush with NOP insertion and a
//             registered occupancy count.
//  Ports    : clk    - rising-edge clock, sole clock domain
//             reset  - synchronous, active-high; priority over everything
//             bus    - pipe_stage_latch_if.slave handshake bundle
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_latch #(
    parameter int                DATA_W   = 32,
    parameter int                N_FIELDS = 4,
    parameter int                INS_IDX  = 2,
    parameter logic [DATA_W-1:0] NOP_VAL  = '0
) (
    input  wire logic            clk,
    input  wire logic            reset,
    pipe_stage_latch_if.slave    bus
);

    localparam int c_PAY_W = N_FIELDS * DATA_W;

    // Returns the payload with its instruction field replaced by a NOP, so an
    // invalid entry can never be mistaken downstream for a live instruction.
    function automatic logic [c_PAY_W-1:0] f_bubble(input logic [c_PAY_W-1:0] p);
        logic [c_PAY_W-1:0] r;
        r = p;
        r[INS_IDX*DATA_W +: DATA_W] = NOP_VAL;
        return r;
    endfunction

    // Main entry drives the outputs; skid entry absorbs the one payload that
    // can arrive in the cycle downstream first stalls.
    logic                 r_mainValid;
    logic [c_PAY_W-1:0]   r_mainData;
    logic                 r_skidValid;
    logic [c_PAY_W-1:0]   r_skidData;
    logic [1:0]           r_occupancy;

    logic                 w_inReady;
    logic                 w_accept;
    logic                 w_consume;
    logic                 w_mainValidNxt;
    logic [c_PAY_W-1:0]   w_mainDataNxt;
    logic                 w_skidValidNxt;
    logic [c_PAY_W-1:0]   w_skidDataNxt;

    // Ready depends only on registered state (and reset), never on out_ready,
    // so no combinational path crosses the latch.
    assign w_inReady = !r_skidValid && !reset;
    assign w_accept  = bus.in_valid && w_inReady;
    assign w_consume = r_mainValid && bus.out_ready;

    always_comb begin
        w_mainValidNxt = r_mainValid;
        w_mainDataNxt  = r_mainData;
        w_skidValidNxt = r_skidValid;
        w_skidDataNxt  = r_skidData;

        if (bus.flush) begin
            // Squash both entries; anything accepted this cycle is dropped.
            w_mainValidNxt = 1'b0;
            w_mainDataNxt  = f_bubble(r_mainData);
            w_skidValidNxt = 1'b0;
            w_skidDataNxt  = f_bubble(r_skidData);
        end else if (!r_mainValid || w_consume) begin
            if (r_skidValid) begin
                // Oldest held payload advances; skid refills only if the
                // upstream handshake fires (it cannot while skid is full,
                // but the rule is kept general).
                w_mainValidNxt = 1'b1;
                w_mainDataNxt  = r_skidData;
                if (w_accept) begin
                    w_skidValidNxt = 1'b1;
                    w_skidDataNxt  = bus.in_data;
                end else begin
                    w_skidValidNxt = 1'b0;
                    w_skidDataNxt  = f_bubble(r_skidData);
                end
            end else if (w_accept) begin
                w_mainValidNxt = 1'b1;
                w_mainDataNxt  = bus.in_data;
            end else begin
                w_mainValidNxt = 1'b0;
                w_mainDataNxt  = f_bubble(r_mainData);
            end
        end else if (w_accept) begin
            // Downstream stalled with main full: park the new payload.
            w_skidValidNxt = 1'b1;
            w_skidDataNxt  = bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mainValid <= 1'b0;
            r_mainData  <= f_bubble('0);
            r_skidValid <= 1'b0;
            r_skidData  <= f_bubble('0);
            r_occupancy <= 2'd0;
        end else begin
            r_mainValid <= w_mainValidNxt;
            r_mainData  <= w_mainDataNxt;
            r_skidValid <= w_skidValidNxt;
            r_skidData  <= w_skidDataNxt;
            r_occupancy <= {1'b0, w_mainValidNxt} + {1'b0, w_skidValidNxt};
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_mainValid;
    assign bus.out_data  = r_mainData;
    assign bus.occupancy = r_occupancy;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_latch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_latch
//  Purpose  : Directed, scoreboard-based bench for pipe_stage_latch.
//             Accepted payloads are queued; every consume pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_latch;

    localparam int DW  = 32;
    localparam int NF  = 4;
    localparam int PW  = DW * NF;
    localparam int INS = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_stage_latch_if #(.DATA_W(DW), .N_FIELDS(NF)) bus ();

    pipe_stage_latch #(
        .DATA_W   (DW),
        .N_FIELDS (NF),
        .INS_IDX  (INS),
        .NOP_VAL  ('0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          pops        = 0;
    logic        lastAcc     = 1'b0;
    logic [PW-1:0] q[$];

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Fields: [0]=O, [1]=B, [2]=instruction, [3]=overflow.
    function automatic logic [PW-1:0] mk(input logic [7:0] o);
        return {32'hA000 + 32'(o), 32'h1000 + 32'(o), 32'hB000 + 32'(o), 32'(o)};
    endfunction

    // Called at a falling edge with inputs already driven. Samples just before
    // the rising edge, then updates the model and checks just after it.
    task automatic tick();
        logic acc, con;
        #4;
        check("in_ready", PW'(bus.in_ready), PW'(!reset && q.size() < 2));
        check("out_valid", PW'(bus.out_valid), PW'(q.size() > 0));
        acc = bus.in_valid && bus.in_ready;
        con = bus.out_valid && bus.out_ready;
        if (con && q.size() > 0) begin
            check("out_data", bus.out_data, q.pop_front());
            pops++;
        end
        @(posedge clk);
        #1;
        if (reset || bus.flush) q.delete();
        else if (acc) q.push_back(bus.in_data);
        lastAcc = acc;
        check("occupancy", PW'(bus.occupancy), PW'(q.size()));
        if (q.size() == 0)
            check("ins_nop", PW'(bus.out_data[INS*DW +: DW]), '0);
        @(negedge clk);
    endtask

    task automatic send(input logic [PW-1:0] p);
        bus.in_valid = 1'b1;
        bus.in_data  = p;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int p0;
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = mk(8'h99);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // 1: reset held two cycles with in_valid high
        tick();
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        tick();

        // 2: streaming at full rate
        bus.out_ready = 1'b1;
        p0 = pops;
        for (int i = 1; i <= 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mk(8'(8'h11 * i));
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("stream_pops", PW'(pops - p0), PW'(3));

        // 3: backpressure fills skid, C held upstream until accepted
        bus.out_ready = 1'b0;
        p0 = pops;
        send(mk(8'hA1));
        send(mk(8'hB2));
        bus.in_valid = 1'b1;
        bus.in_data  = mk(8'hC3);
        tick();
        tick();
        bus.out_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!lastAcc && n < 8);
        check("c_accepted", PW'(lastAcc), PW'(1));
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("bp_pops", PW'(pops - p0), PW'(3));

        // 4: flush while full, D offered in the flush cycle
        bus.out_ready = 1'b0;
        send(mk(8'hA4));
        send(mk(8'hB4));
        p0 = pops;
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = mk(8'hD4);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("flush_full_pops", PW'(pops - p0), PW'(0));

        // 5: flush with concurrent consume, then E flows normally
        bus.out_ready = 1'b0;
        send(mk(8'hA5));
        p0 = pops;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        tick();
        bus.flush = 1'b0;
        send(mk(8'hE5));
        tick();
        tick();
        check("flush_consume_pops", PW'(pops - p0), PW'(2));

        // 6: reset mid-stream with both entries full
        bus.out_ready = 1'b0;
        send(mk(8'hA6));
        send(mk(8'hB6));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send(mk(8'hF6));
        check("post_reset_valid", PW'(bus.out_valid), PW'(1));
        check("post_reset_data", bus.out_data, mk(8'hF6));
        bus.out_ready = 1'b1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
